// File: rtl/sram_port_arbiter.sv
// Arbitrates the single SRAM controller port between instruction fetch (read-only)
// and the MEM stage (read/write). MEM has priority; a starvation counter forces a
// fetch grant once fetch has waited STARVE_LIMIT cycles. The winning request is
// latched and held on the SRAM side until the controller signals completion.
module sram_port_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   // fetch requester
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_freeze,
   // MEM-stage requester
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ready,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_freeze,
   // SRAM controller side
   output logic              sram_req,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   input  logic              sram_ready
);

   localparam int unsigned     CntW      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      StIdle,
      StIfBusy,
      StMemBusy
   } state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     starve_q, starve_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                grant_mem, grant_if;

   // Grant decision; only IDLE can grant, busy states ignore requesters entirely.
   always_comb begin
      grant_mem = 1'b0;
      grant_if  = 1'b0;
      if (state_q == StIdle) begin
         if (mem_req && (!if_req || (starve_q < StarveMax))) begin
            grant_mem = 1'b1;
         end else if (if_req) begin
            grant_if = 1'b1;
         end
      end
   end

   // Next state, latched transaction fields and fetch starvation count.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;

      unique case (state_q)
         StIdle: begin
            if (grant_mem) begin
               state_d = StMemBusy;
               we_d    = mem_we;
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
            end else if (grant_if) begin
               state_d = StIfBusy;
               we_d    = 1'b0;
               addr_d  = if_addr;
               wdata_d = '0;
            end
         end
         StIfBusy, StMemBusy: begin
            if (sram_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Fetch waits while MEM is granted or busy; the count saturates at the limit.
      if (grant_if) begin
         starve_d = '0;
      end else if (if_req && (state_q != StIfBusy) && (starve_q != StarveMax)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // State registers with synchronous reset; reset aborts any transaction silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         starve_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   // Outputs decoded from registered state; ready pulses pass sram_ready straight through.
   always_comb begin
      sram_req   = (state_q != StIdle);
      sram_we    = we_q;
      sram_addr  = addr_q;
      sram_wdata = wdata_q;
      if_ready   = (state_q == StIfBusy) && sram_ready;
      mem_ready  = (state_q == StMemBusy) && sram_ready;
      if_rdata   = sram_rdata;
      mem_rdata  = sram_rdata;
      if_freeze  = if_req && !if_ready;
      mem_freeze = mem_req && !mem_ready;
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_sram_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int          SL = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, if_ready, if_freeze;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          mem_req, mem_we, mem_ready, mem_freeze;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          sram_req, sram_we, sram_ready;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata, sram_rdata;

   always #5 clk = ~clk;

   sram_port_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_ready   (if_ready),
      .if_rdata   (if_rdata),
      .if_freeze  (if_freeze),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .mem_freeze (mem_freeze),
      .sram_req   (sram_req),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_ready (sram_ready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: who owns the port (0 none, 1 fetch, 2 MEM), how long fetch
   // has been kept waiting, and the fields captured when the owner was granted.
   int            m_owner;
   int            m_wait;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          e_if_ready, e_mem_ready;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_wait  = 0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else if (m_owner == 0) begin
         if (mem_req && (!if_req || m_wait < SL)) begin
            m_owner = 2;
            m_we    = mem_we;
            m_addr  = mem_addr;
            m_wdata = mem_wdata;
            if (if_req && m_wait < SL) m_wait++;
         end else if (if_req) begin
            m_owner = 1;
            m_we    = 1'b0;
            m_addr  = if_addr;
            m_wdata = '0;
            m_wait  = 0;
         end
      end else begin
         if (m_owner == 2 && if_req && m_wait < SL) m_wait++;
         if (sram_ready) m_owner = 0;
      end
   endtask

   // Called at a falling edge with inputs already driven: check, then cross one edge.
   task automatic step();
      #1;
      e_if_ready  = (m_owner == 1) && sram_ready;
      e_mem_ready = (m_owner == 2) && sram_ready;
      check_eq("sram_req", sram_req, m_owner != 0);
      check_eq("sram_we", sram_we, m_we);
      check_eq("sram_addr", sram_addr, m_addr);
      check_eq("sram_wdata", sram_wdata, m_wdata);
      check_eq("if_ready", if_ready, e_if_ready);
      check_eq("mem_ready", mem_ready, e_mem_ready);
      check_eq("if_freeze", if_freeze, if_req && !e_if_ready);
      check_eq("mem_freeze", mem_freeze, mem_req && !e_mem_ready);
      if (e_if_ready) check_eq("if_rdata", if_rdata, sram_rdata);
      if (e_mem_ready && !m_we) check_eq("mem_rdata", mem_rdata, sram_rdata);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drain();
      if_req  = 1'b0;
      mem_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sram_ready = (m_owner != 0);
         step();
      end
      sram_ready = 1'b0;
   endtask

   logic dut_grants[$];
   logic exp_grants[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic prev_sram_req;
   int   pulses, busy_n;
   bit   was_busy, if_done, mem_done;

   initial begin
      model_reset();
      rst = 1'b1;
      {if_req, mem_req, mem_we, sram_ready} = '0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0; sram_rdata = '0;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      #1;
      check_eq("rst_sram_req", sram_req, 1'b0);
      check_eq("rst_sram_we", sram_we, 1'b0);
      check_eq("rst_sram_addr", sram_addr, 0);
      check_eq("rst_sram_wdata", sram_wdata, 0);
      check_eq("rst_if_ready", if_ready, 1'b0);
      check_eq("rst_mem_ready", mem_ready, 1'b0);
      @(negedge clk);

      // Fetch read, data returned on the third busy cycle.
      if_req  = 1'b1;
      if_addr = 32'h10;
      step();
      check_eq("if_grant_req", sram_req, 1'b1);
      check_eq("if_grant_addr", sram_addr, 32'h10);
      check_eq("if_grant_we", sram_we, 1'b0);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         sram_ready = (i == 2);
         sram_rdata = (i == 2) ? 32'hDEADBEEF : 32'h0;
         #1;
         if (if_ready) pulses++;
         check_eq("if_freeze_hold", if_freeze, i != 2);
         if (i == 2) check_eq("if_rdata_val", if_rdata, 32'hDEADBEEF);
         step();
      end
      if_req     = 1'b0;
      sram_ready = 1'b0;
      #1;
      if (if_ready) pulses++;
      check_eq("if_ready_pulses", pulses, 1);
      step();

      // MEM write; the requester's address changes mid-transaction and must be ignored.
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = 32'h40;
      mem_wdata = 32'h1234;
      step();
      mem_addr = 32'h99;
      for (int i = 0; i < 3; i++) begin
         sram_ready = (i == 2);
         #1;
         check_eq("memw_addr", sram_addr, 32'h40);
         check_eq("memw_we", sram_we, 1'b1);
         check_eq("memw_wdata", sram_wdata, 32'h1234);
         check_eq("memw_ready", mem_ready, i == 2);
         step();
      end
      mem_req    = 1'b0;
      sram_ready = 1'b0;
      step();

      // Contention: both held high, two-cycle transactions; fetch wins every third grant.
      if_req        = 1'b1;
      if_addr       = 32'h100;
      mem_req       = 1'b1;
      mem_we        = 1'b1;
      mem_addr      = 32'h200;
      busy_n        = 0;
      prev_sram_req = sram_req;
      for (int i = 0; i < 18; i++) begin
         sram_ready = (m_owner != 0) && (busy_n == 1);
         if (sram_req && !prev_sram_req) dut_grants.push_back(sram_we);
         prev_sram_req = sram_req;
         was_busy      = (m_owner != 0);
         step();
         busy_n = was_busy ? busy_n + 1 : 0;
         if (m_owner == 0) busy_n = 0;
      end
      check_eq("cont_ngrants", dut_grants.size(), 6);
      for (int k = 0; k < 6; k++) begin
         if (k < dut_grants.size()) check_eq($sformatf("cont_grant%0d", k), dut_grants[k],
                                             exp_grants[k]);
      end
      drain();

      // Reset in the middle of a MEM read, then a spurious ready while idle.
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_addr = 32'h80;
      step();
      step();
      rst = 1'b1;
      step();
      rst        = 1'b0;
      mem_req    = 1'b0;
      sram_ready = 1'b1;
      #1;
      check_eq("mrst_sram_req", sram_req, 1'b0);
      check_eq("mrst_mem_ready", mem_ready, 1'b0);
      step();
      sram_ready = 1'b0;
      if_req     = 1'b1;
      if_addr    = 32'h20;
      step();
      check_eq("mrst_if_grant", sram_req, 1'b1);
      check_eq("mrst_if_addr", sram_addr, 32'h20);
      drain();
      sram_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("spur_if_ready", if_ready, 1'b0);
         check_eq("spur_mem_ready", mem_ready, 1'b0);
         check_eq("spur_sram_req", sram_req, 1'b0);
         step();
      end

      // Random traffic against the model.
      if_done  = 1'b0;
      mem_done = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!if_req || if_done) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = $urandom;
         end else if (m_owner == 1 && $urandom_range(0, 19) == 0) begin
            if_req = 1'b0;
         end
         if (!mem_req || mem_done) begin
            mem_req   = ($urandom_range(0, 2) != 0);
            mem_we    = $urandom_range(0, 1);
            mem_addr  = $urandom;
            mem_wdata = $urandom;
         end else if (m_owner == 2 && $urandom_range(0, 19) == 0) begin
            mem_req = 1'b0;
         end
         sram_ready = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         sram_rdata = $urandom;
         rst        = ($urandom_range(0, 99) == 0);
         step();
         if_done  = e_if_ready;
         mem_done = e_mem_ready;
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
